// File: rtl/uart_pkg.sv
// Shared types and helpers for the parameterised UART receiver.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // 2-of-3 vote used to reject single-sample noise within a bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Clock cycles per oversample tick, truncated.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV enabled clocks; clear realigns the phase.
module rx_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = enable && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit sampling and break handling.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit, PARITY_ODD selects odd/even).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RX_Pin_In,
    input  logic                 RX_En_Sig,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 Frame_Err,
    output logic                 Parity_Err,
    output logic                 Busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE + 1);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_LO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_HI  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_rx_param: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
            (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
            $error("uart_rx_param: parameter out of legal range");
        end
    endgenerate

    // Line synchroniser; flops reset to the idle (high) level so reset never fakes an edge.
    logic rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
    logic rx_s, fall_edge;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
        end else begin
            rx_sync1_reg <= RX_Pin_In;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
        end
    end

    assign rx_s      = rx_sync2_reg;
    assign fall_edge = rx_prev_reg & ~rx_sync2_reg;

    rx_state_t            state_reg, state_next;
    logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [1:0]           samp_reg, samp_next;
    logic                 stop_err_reg, stop_err_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 done_reg, done_next;
    logic                 frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_reg, parity_bit_next;
    logic                 parity_err_reg, parity_err_next;
`endif

    logic          tick, tick_clear, tick_en;
    logic [TW-1:0] tick_num;
    logic          bit_end, mid_hi, vote, frame_bad;

    assign tick_en = (state_reg != IDLE);

    rx_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk   (CLK),
        .rst_n (RSTn),
        .clear (tick_clear),
        .enable(tick_en),
        .tick  (tick)
    );

    assign tick_num  = tick_cnt_reg + TW'(1);
    assign bit_end   = tick && (tick_num == T_END);
    assign mid_hi    = tick && (tick_num == T_HI);
    assign vote      = majority3(samp_reg[0], samp_reg[1], rx_s);
    assign frame_bad = stop_err_reg | ~vote;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            samp_reg       <= '0;
            stop_err_reg   <= 1'b0;
            rx_data_reg    <= '0;
            done_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            samp_reg       <= samp_next;
            stop_err_reg   <= stop_err_next;
            rx_data_reg    <= rx_data_next;
            done_reg       <= done_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        samp_next       = samp_reg;
        stop_err_next   = stop_err_reg;
        rx_data_next    = rx_data_reg;
        done_next       = 1'b0;
        frame_err_next  = frame_err_reg;
        tick_clear      = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = parity_err_reg;
`endif

        if (tick) begin
            tick_cnt_next = bit_end ? '0 : tick_num;
            if (tick_num == T_LO)  samp_next[0] = rx_s;
            if (tick_num == T_MID) samp_next[1] = rx_s;
        end

        case (state_reg)
            IDLE: begin
                tick_cnt_next = '0;
                if (RX_En_Sig && fall_edge) begin
                    state_next    = START;
                    tick_clear    = 1'b1;
                    stop_err_next = 1'b0;
                end
            end
            START: begin
                if (tick && tick_num == T_MID && rx_s) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (mid_hi) shift_next = {vote, shift_reg[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_hi) parity_bit_next = vote;
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (mid_hi) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        // Frame complete at the last stop sample; results appear with the pulse next cycle.
                        done_next      = 1'b1;
                        rx_data_next   = shift_reg;
                        frame_err_next = frame_bad;
`ifdef UART_RX_PARITY_EN
                        parity_err_next = (^shift_reg) ^ parity_bit_reg ^ 1'(PARITY_ODD);
`endif
                        tick_clear     = 1'b1;
                        tick_cnt_next  = '0;
                        bit_cnt_next   = '0;
                        state_next     = frame_bad ? WAIT_HIGH : IDLE;
                    end else begin
                        stop_err_next = frame_bad;
                    end
                end else if (bit_end) begin
                    bit_cnt_next = bit_cnt_reg + BW'(1);
                end
            end
            WAIT_HIGH: begin
                // Any low level restarts the full-bit high qualification.
                if (!rx_s) begin
                    tick_cnt_next = '0;
                end else if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign RX_Data     = rx_data_reg;
    assign RX_Done_Sig = done_reg;
    assign Frame_Err   = frame_err_reg;
    assign Busy        = tick_en;
`ifdef UART_RX_PARITY_EN
    assign Parity_Err  = parity_err_reg;
`else
    assign Parity_Err  = 1'b0;
`endif

endmodule
